// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline write-back always wins, host writes
// queue in a 2-entry FIFO and drain on idle write-back cycles, with a stall request on starvation.
module wb_port_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 4,
  parameter int STARVE_LIMIT   = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wb_wen,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd_addr,
  input  logic [DATA_WIDTH-1:0]     wb_wdata,
  input  logic                      host_valid,
  output logic                      host_ready,
  input  logic [REG_ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0]     host_wdata,
  output logic                      host_ack,
  output logic                      pipe_stall_req,
  output logic                      rf_wen,
  output logic [REG_ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0]     rf_wdata
);

  // state | meaning
  // IDLE  | host FIFO empty
  // PEND  | host write(s) queued, waiting for an idle write-back cycle
  // STALL | head starved for STARVE_LIMIT cycles; pipeline freeze requested
  typedef enum logic [1:0] {IDLE = 2'd0, PEND = 2'd1, STALL = 2'd2} state_t;

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  state_t                    state, state_next;
  logic [REG_ADDR_WIDTH-1:0] fifo_addr [2];
  logic [DATA_WIDTH-1:0]     fifo_data [2];
  logic                      rd_ptr, wr_ptr;
  logic [1:0]                count;
  logic [CW-1:0]             starve_cnt;
  logic                      push, pop;

  assign host_ready = !reset && (count < 2'd2);
  assign push       = host_valid && host_ready;
  assign pop        = !reset && !wb_wen && (count != 2'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      count    <= 2'd0;
      host_ack <= 1'b0;
    end else begin
      host_ack <= pop;
      if (push) begin
        fifo_addr[wr_ptr] <= host_addr;
        fifo_data[wr_ptr] <= host_wdata;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || pop || count == 2'd0)
      starve_cnt <= '0;
    else if (wb_wen && starve_cnt != LIMIT)
      starve_cnt <= starve_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (push) state_next = PEND;
      PEND: begin
        if (pop && count == 2'd1 && !push) state_next = IDLE;
        else if (!pop && starve_cnt == LIMIT) state_next = STALL;
      end
      STALL: if (pop) state_next = (count == 2'd1 && !push) ? IDLE : PEND;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    pipe_stall_req = (state == STALL);
  end

  // Write-back has absolute priority; the host head only uses idle cycles.
  always_comb begin
    rf_wen   = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (wb_wen) begin
      rf_wen   = 1'b1;
      rf_waddr = wb_rd_addr;
      rf_wdata = wb_wdata;
    end else if (count != 2'd0) begin
      rf_wen   = 1'b1;
      rf_waddr = fifo_addr[rd_ptr];
      rf_wdata = fifo_data[rd_ptr];
    end
    if (reset) rf_wen = 1'b0;
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a queue-based reference model.
module tb_wb_port_arbiter;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int L  = 8;

  logic          clk, reset;
  logic          wb_wen, host_valid;
  logic [AW-1:0] wb_rd_addr, host_addr;
  logic [DW-1:0] wb_wdata, host_wdata;
  logic          host_ready, host_ack, pipe_stall_req, rf_wen;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;

  int checks = 0;
  int errors = 0;

  wb_port_arbiter #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .STARVE_LIMIT(L)) dut (
    .clk(clk), .reset(reset),
    .wb_wen(wb_wen), .wb_rd_addr(wb_rd_addr), .wb_wdata(wb_wdata),
    .host_valid(host_valid), .host_ready(host_ready),
    .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .pipe_stall_req(pipe_stall_req),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending host writes as a queue, blocked-cycle count, stall flag.
  typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } entry_t;
  entry_t q[$];
  int     blk;
  bit     m_stall, m_ack, model_ok;

  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      blk = 0; m_stall = 0; m_ack = 0; model_ok = 1;
    end else if (model_ok) begin
      bit pop_now, push_now;
      entry_t e;
      pop_now  = !wb_wen && q.size() > 0;
      push_now = host_valid && q.size() < 2;
      m_ack    = pop_now;
      if (pop_now)       m_stall = 0;
      else if (blk >= L) m_stall = 1;
      if (pop_now || q.size() == 0) blk = 0;
      else if (wb_wen && blk < L)   blk = blk + 1;
      if (pop_now) void'(q.pop_front());
      if (push_now) begin
        e.a = host_addr; e.d = host_wdata;
        q.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      chk("host_ready", {31'd0, host_ready}, {31'd0, !reset && q.size() < 2});
      chk("host_ack", {31'd0, host_ack}, {31'd0, m_ack});
      chk("pipe_stall_req", {31'd0, pipe_stall_req}, {31'd0, m_stall});
      chk("rf_wen", {31'd0, rf_wen}, {31'd0, !reset && (wb_wen || q.size() > 0)});
      if (!reset) begin
        if (wb_wen) begin
          chk("rf_waddr_wb", {28'd0, rf_waddr}, {28'd0, wb_rd_addr});
          chk("rf_wdata_wb", rf_wdata, wb_wdata);
        end else if (q.size() > 0) begin
          chk("rf_waddr_host", {28'd0, rf_waddr}, {28'd0, q[0].a});
          chk("rf_wdata_host", rf_wdata, q[0].d);
        end else begin
          chk("rf_waddr_idle", {28'd0, rf_waddr}, 32'd0);
          chk("rf_wdata_idle", rf_wdata, 32'd0);
        end
      end
    end
  end

  task automatic drive(input logic rst, input logic w, input logic [AW-1:0] wa,
                       input logic [DW-1:0] wd, input logic hv,
                       input logic [AW-1:0] ha, input logic [DW-1:0] hd);
    @(posedge clk);
    #1;
    reset = rst; wb_wen = w; wb_rd_addr = wa; wb_wdata = wd;
    host_valid = hv; host_addr = ha; host_wdata = hd;
    #4;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    model_ok = 0;
    reset = 1; wb_wen = 0; wb_rd_addr = 0; wb_wdata = 0;
    host_valid = 0; host_addr = 0; host_wdata = 0;
    drive(1, 0, 0, 0, 0, 0, 0);
    chk("reset_rf_wen", {31'd0, rf_wen}, 32'd0);
    chk("reset_host_ready", {31'd0, host_ready}, 32'd0);
    drive(1, 0, 0, 0, 0, 0, 0);
    chk("reset_ack", {31'd0, host_ack}, 32'd0);
    chk("reset_stall", {31'd0, pipe_stall_req}, 32'd0);

    // Pipeline pass-through
    drive(0, 1, 4'd3, 32'hDEADBEEF, 0, 0, 0);
    chk("wb_pass_wen", {31'd0, rf_wen}, 32'd1);
    chk("wb_pass_addr", {28'd0, rf_waddr}, 32'd3);
    chk("wb_pass_data", rf_wdata, 32'hDEADBEEF);
    chk("wb_pass_ack", {31'd0, host_ack}, 32'd0);
    chk("ready_after_reset", {31'd0, host_ready}, 32'd1);

    // Single host write on an idle pipeline
    drive(0, 0, 0, 0, 1, 4'd5, 32'h11);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("host1_wen", {31'd0, rf_wen}, 32'd1);
    chk("host1_addr", {28'd0, rf_waddr}, 32'd5);
    chk("host1_data", rf_wdata, 32'h11);
    chk("host1_ack_early", {31'd0, host_ack}, 32'd0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("host1_ack", {31'd0, host_ack}, 32'd1);
    chk("host1_idle_wen", {31'd0, rf_wen}, 32'd0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("host1_ack_once", {31'd0, host_ack}, 32'd0);

    // FIFO fill with write-back busy, then in-order drain
    drive(0, 1, 4'd0, 32'h0, 1, 4'd1, 32'h101);
    chk("fill_ready0", {31'd0, host_ready}, 32'd1);
    drive(0, 1, 4'd0, 32'h0, 1, 4'd2, 32'h102);
    chk("fill_ready1", {31'd0, host_ready}, 32'd1);
    drive(0, 1, 4'd0, 32'h0, 1, 4'd3, 32'h103);
    chk("fill_full", {31'd0, host_ready}, 32'd0);
    drive(0, 0, 0, 0, 1, 4'd3, 32'h103);
    chk("drain0_addr", {28'd0, rf_waddr}, 32'd1);
    chk("drain0_ready", {31'd0, host_ready}, 32'd0);
    chk("drain0_ack", {31'd0, host_ack}, 32'd0);
    drive(0, 0, 0, 0, 1, 4'd3, 32'h103);
    chk("drain1_addr", {28'd0, rf_waddr}, 32'd2);
    chk("drain1_ready", {31'd0, host_ready}, 32'd1);
    chk("drain1_ack", {31'd0, host_ack}, 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("drain2_addr", {28'd0, rf_waddr}, 32'd3);
    chk("drain2_data", rf_wdata, 32'h103);
    chk("drain2_ack", {31'd0, host_ack}, 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("drain3_ack", {31'd0, host_ack}, 32'd1);
    chk("drain3_wen", {31'd0, rf_wen}, 32'd0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("drain4_ack", {31'd0, host_ack}, 32'd0);

    // Starvation: one queued write, write-back busy for 12 cycles
    drive(0, 1, 4'd1, 32'h1, 1, 4'd9, 32'h99);
    for (int i = 0; i < 12; i++) begin
      drive(0, 1, 4'd1, 32'h1, 0, 0, 0);
      chk($sformatf("starve_stall_%0d", i), {31'd0, pipe_stall_req}, (i >= 9) ? 32'd1 : 32'd0);
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("starve_commit_addr", {28'd0, rf_waddr}, 32'd9);
    chk("starve_commit_data", rf_wdata, 32'h99);
    chk("starve_stall_held", {31'd0, pipe_stall_req}, 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("starve_stall_fall", {31'd0, pipe_stall_req}, 32'd0);
    chk("starve_ack", {31'd0, host_ack}, 32'd1);

    // Address collision: write-back wins, host entry waits
    drive(0, 1, 4'd2, 32'h2, 1, 4'd7, 32'hBB);
    drive(0, 1, 4'd7, 32'hAA, 0, 0, 0);
    chk("collide_wb_addr", {28'd0, rf_waddr}, 32'd7);
    chk("collide_wb_data", rf_wdata, 32'hAA);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("collide_host_data", rf_wdata, 32'hBB);
    idle(2);

    // Reset with two entries queued
    drive(0, 1, 4'd1, 32'h1, 1, 4'd1, 32'h51);
    drive(0, 1, 4'd1, 32'h1, 1, 4'd2, 32'h52);
    drive(1, 0, 0, 0, 0, 0, 0);
    chk("midrst_rf_wen", {31'd0, rf_wen}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      chk($sformatf("postrst_ack_%0d", i), {31'd0, host_ack}, 32'd0);
      chk($sformatf("postrst_wen_%0d", i), {31'd0, rf_wen}, 32'd0);
      chk($sformatf("postrst_stall_%0d", i), {31'd0, pipe_stall_req}, 32'd0);
      chk($sformatf("postrst_ready_%0d", i), {31'd0, host_ready}, 32'd1);
    end

    // Randomized traffic with varying write-back load
    for (int i = 0; i < 3000; i++) begin
      int bias;
      case ((i / 200) % 3)
        0:       bias = 20;
        1:       bias = 60;
        default: bias = 97;
      endcase
      drive(($urandom_range(0, 299) == 0),
            ($urandom_range(0, 99) < bias),
            AW'($urandom), $urandom,
            ($urandom_range(0, 1) == 1),
            AW'($urandom), $urandom);
    end
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
